// File: rtl/delay_sched.sv
// Inertial/transport delay scheduler for s = ai & bi with a configurable delay D.
// Optional drop counter enabled by defining DELAY_SCHED_DROP_CNT_EN; otherwise drop_cnt is tied to 0.
module delay_sched #(
   parameter int DW          = 5,
   parameter int DEFAULT_DLY = 4
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          ai,
   input  logic          bi,
   input  logic          cfg_valid,
   input  logic [DW-1:0] cfg_dly,
   output logic          cfg_ready,
   output logic          so_inertial,
   output logic          so_transport,
   output logic          busy,
   output logic [7:0]    drop_cnt
);
   localparam int DEPTH = (1 << DW) - 1;

   typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, CFG = 2'd2} state_t;

   state_t          state, state_nx;
   logic [DW-1:0]   dly, dly_nx;
   logic [DW-1:0]   cnt, cnt_nx;
   logic [DW-1:0]   tap;
   logic [DEPTH-1:0] dly_pipe;
   logic            s;
   logic            toggle;

   assign s   = ai & bi;
   assign tap = dly - 1'b1;

   // PEND holds D qualifying samples; the edge after the D-th one commits the toggle.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      dly_nx   = dly;
      toggle   = 1'b0;
      case (state)
         IDLE: begin
            if (cfg_valid) begin
               dly_nx   = (cfg_dly == '0) ? DW'(1) : cfg_dly;
               state_nx = CFG;
            end else if (s != so_inertial) begin
               cnt_nx   = DW'(1);
               state_nx = PEND;
            end
         end
         PEND: begin
            if (cnt == dly) begin
               toggle   = 1'b1;
               cnt_nx   = '0;
               state_nx = IDLE;
            end else if (s != so_inertial) begin
               cnt_nx   = cnt + 1'b1;
            end else begin
               cnt_nx   = '0;
               state_nx = IDLE;
            end
         end
         CFG:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= IDLE;
         cnt          <= '0;
         dly          <= DW'(DEFAULT_DLY);
         dly_pipe     <= '0;
         so_inertial  <= 1'b0;
         so_transport <= 1'b0;
         busy         <= 1'b0;
         cfg_ready    <= 1'b1;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         dly       <= dly_nx;
         busy      <= (state_nx != IDLE);
         cfg_ready <= (state_nx == IDLE);
         if (toggle) so_inertial <= ~so_inertial;
         // Flush aligns the transport history with the settled inertial value.
         if (state == CFG) begin
            dly_pipe     <= {DEPTH{so_inertial}};
            so_transport <= so_inertial;
         end else begin
            dly_pipe     <= {dly_pipe[DEPTH-2:0], s};
            so_transport <= dly_pipe[tap];
         end
      end
   end

`ifdef DELAY_SCHED_DROP_CNT_EN
   logic drop;
   assign drop = (state == PEND) && (cnt != dly) && (s == so_inertial);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                          drop_cnt <= '0;
      else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
   end
`else
   assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_delay_sched.sv
// Randomized and directed bench for delay_sched against a timestamp/queue reference model.
module tb_delay_sched;
   localparam int DW          = 5;
   localparam int DEFAULT_DLY = 4;
`ifdef DELAY_SCHED_DROP_CNT_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rstn;
   logic          ai, bi, cfg_valid;
   logic [DW-1:0] cfg_dly;
   logic          cfg_ready, so_inertial, so_transport, busy;
   logic [7:0]    drop_cnt;

   delay_sched #(.DW(DW), .DEFAULT_DLY(DEFAULT_DLY)) dut (
      .clk(clk), .rstn(rstn), .ai(ai), .bi(bi),
      .cfg_valid(cfg_valid), .cfg_dly(cfg_dly), .cfg_ready(cfg_ready),
      .so_inertial(so_inertial), .so_transport(so_transport),
      .busy(busy), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s got %0h exp %0h", nm, act, exp);
   endtask

   // Reference model: a change is pending from the edge it was first seen;
   // it commits D edges later unless s returns to the output first.
   bit m_i, m_t, m_flush, m_xfer;
   int m_d, m_drops, pend_start, t;
   bit q[$];

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_i = 0; m_t = 0; m_d = DEFAULT_DLY; m_drops = 0;
         pend_start = -1; m_flush = 0; m_xfer = 0;
         q.delete();
      end else begin
         bit s;
         s = ai & bi;
         m_xfer = 0;
         if (m_flush) begin
            m_t = m_i;
            q.delete();
            repeat (32) q.push_front(m_i);
            m_flush = 0;
         end else begin
            m_t = (q.size() >= m_d) ? q[m_d-1] : 1'b0;
            q.push_front(s);
            if (q.size() > 40) void'(q.pop_back());
            if (pend_start < 0) begin
               if (cfg_valid) begin
                  m_d = (cfg_dly == 0) ? 1 : int'(cfg_dly);
                  m_flush = 1; m_xfer = 1;
               end else if (s != m_i) pend_start = t;
            end else if (t - pend_start == m_d) begin
               m_i = !m_i; pend_start = -1;
            end else if (s == m_i) begin
               pend_start = -1;
               if (m_drops < 255) m_drops++;
            end
         end
         t++;
      end
   end

   always @(negedge clk) begin
      if (chk_on && rstn) begin
         chk("so_inertial", so_inertial, m_i);
         chk("so_transport", so_transport, m_t);
         chk("busy", busy, m_flush || pend_start >= 0);
         chk("cfg_ready", cfg_ready, !(m_flush || pend_start >= 0));
         chk("drop_cnt", drop_cnt, DROP_EN ? m_drops : 0);
      end
   end

   task automatic set_s(input bit v);
      int r;
      if (v) begin ai = 1; bi = 1; end
      else begin
         r = $urandom_range(0, 2);
         ai = (r == 1); bi = (r == 2);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_cfg(input logic [DW-1:0] v);
      cfg_valid = 1; cfg_dly = v;
      @(negedge clk); cfg_valid = 0;
      @(negedge clk);
   endtask

   logic [31:0] v1, v2;

   initial begin
      rstn = 0; ai = 0; bi = 0; cfg_valid = 0; cfg_dly = '0;
      cyc(2);
      #1;
      chk("rst_so_i", so_inertial, 0);
      chk("rst_so_t", so_transport, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", cfg_ready, 1);
      chk("rst_drop", drop_cnt, 0);
      @(negedge clk); rstn = 1; chk_on = 1;
      cyc(2);

      // D=4, 3-cycle pulse is filtered, transport keeps it
      set_s(1); v1 = 0; v2 = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         v1[i] = so_transport; v2[i] = so_inertial;
         if (i == 2) set_s(0);
      end
      chk("p3_trans", v1, 32'h070);
      chk("p3_inert", v2, 32'h000);
      chk("p3_drop", drop_cnt, DROP_EN ? 1 : 0);

      // D=4, 5-cycle pulse passes both paths
      set_s(1); v1 = 0; v2 = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         v1[i] = so_transport; v2[i] = so_inertial;
         if (i == 4) set_s(0);
      end
      chk("p5_trans", v1, 32'h1F0);
      chk("p5_inert", v2, 32'h1F0);

      // cfg_dly=0 stores D=1 with a one-cycle flush
      cfg_valid = 1; cfg_dly = '0;
      @(negedge clk);
      chk("cfg0_busy", busy, 1);
      chk("cfg0_ready", cfg_ready, 0);
      cfg_valid = 0;
      @(negedge clk);
      chk("cfg0_busy_end", busy, 0);
      set_s(1); v1 = 0; v2 = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         v1[i] = so_transport; v2[i] = so_inertial;
         if (i == 0) set_s(0);
      end
      chk("d1_trans", v1, 32'h02);
      chk("d1_inert", v2, 32'h06);

      // config request held during PEND waits for IDLE
      do_cfg(5'd7);
      set_s(1); v1 = 0; v2 = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         v1[i] = cfg_ready; v2[i] = busy;
         if (i == 0) begin cfg_valid = 1; cfg_dly = 5'd10; end
         if (i == 8) cfg_valid = 0;
      end
      chk("hold_ready", v1, 32'h280);
      chk("hold_busy", v2, 32'h17F);
      set_s(0); v1 = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         v1[i] = so_transport;
      end
      chk("d10_trans", v1, 32'h3FF);

      // reset mid-PEND with D=7
      do_cfg(5'd7);
      set_s(1); cyc(9);
      set_s(0); cyc(2);
      chk("pre_rst_inert", so_inertial, 1);
      chk("pre_rst_busy", busy, 1);
      #2 rstn = 0;
      #1;
      chk("mid_rst_so_i", so_inertial, 0);
      chk("mid_rst_so_t", so_transport, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", cfg_ready, 1);
      chk("mid_rst_drop", drop_cnt, 0);
      @(negedge clk); rstn = 1;
      cyc(1);
      set_s(1); v2 = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         v2[i] = so_inertial;
      end
      chk("post_rst_d4", v2, 32'h30);
      set_s(0); cyc(8);

      // saturation of the drop counter
      do_cfg(5'd2);
      for (int k = 0; k < 300; k++) begin
         set_s(1); cyc(1);
         set_s(0); cyc(1);
      end
      cyc(2);
      chk("drop_sat", drop_cnt, DROP_EN ? 255 : 0);

      // randomized traffic with held config requests and one async reset pulse
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (m_xfer) cfg_valid = 0;
         if ($urandom_range(0, 3) == 0) set_s(1'($urandom_range(0, 1)));
         if (!cfg_valid && $urandom_range(0, 39) == 0) begin
            cfg_valid = 1;
            cfg_dly = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 31))
                                                  : DW'($urandom_range(0, 6));
         end
         if (c == 1500) begin #2 rstn = 0; #1 rstn = 1; end
      end
      cfg_valid = 0;
      cyc(2);
      chk_on = 0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
